// File: rtl/async_fifo_buffer.sv
// async_fifo_buffer: req/ack elastic FIFO on one dataflow edge, one-cycle ack pulses to all consumers
module async_fifo_buffer #(
    parameter int data_width  = 32,
    parameter int depth       = 4,
    parameter int output_size = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    output logic                         req_l,
    input  logic                         ack_l,
    input  logic [data_width-1:0]        din,
    input  logic [output_size-1:0]       req_r,
    output logic                         ack_r,
    output logic [data_width-1:0]        dout,
    output logic [$clog2(depth+1)-1:0]   level
);
    localparam int aw = $clog2(depth);
    localparam int lw = $clog2(depth + 1);
    localparam logic [lw-1:0] full = lw'(depth);
    typedef enum logic {s_idle, s_ack} state_t;
    state_t state, state_nx;
    logic [data_width-1:0] mem [depth];
    logic [aw-1:0] wr_ptr, rd_ptr;
    logic push, pop;
    assign push  = req_l & ack_l;
    assign ack_r = state == s_ack;
    // the ACK state blocks re-evaluation of req_r so a lingering request is never served twice
    always_comb begin
        pop      = state == s_idle && level != '0 && &req_r;
        state_nx = pop ? s_ack : s_idle;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= s_idle;
            req_l  <= 1'b0;
            dout   <= '0;
            level  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            state  <= state_nx;
            req_l  <= push ? 1'b0 : (req_l | (level < full));
            level  <= level + lw'(push) - lw'(pop);
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                dout   <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end
endmodule

// File: tb/tb_async_fifo_buffer.sv
// tb_async_fifo_buffer: randomized req/ack stimulus checked against a queue-based reference model
module tb_async_fifo_buffer;
    localparam int dw = 32;
    localparam int dp = 4;
    localparam int os = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_l, ack_r;
    logic ack_l = 1'b0;
    logic [dw-1:0] din = '0;
    logic [dw-1:0] dout;
    logic [os-1:0] req_r = '0;
    logic [2:0] level;
    int n_cmp = 0;
    int n_err = 0;
    logic [dw-1:0] q [$];
    logic m_req_l = 1'b0;
    logic m_ack_r = 1'b0;
    logic [dw-1:0] m_dout = '0;

    always #5 clk = ~clk;

    async_fifo_buffer #(.data_width(dw), .depth(dp), .output_size(os)) dut (
        .clk(clk), .rst(rst), .req_l(req_l), .ack_l(ack_l), .din(din),
        .req_r(req_r), .ack_r(ack_r), .dout(dout), .level(level)
    );

    task automatic chk(input string tag, input logic [dw-1:0] got, input logic [dw-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock edge: predict from the handshake rules, then compare all outputs
    task automatic cycle();
        int lvl0 = q.size();
        bit push = m_req_l && ack_l;
        bit pop = !m_ack_r && lvl0 > 0 && &req_r;
        if (pop) m_dout = q.pop_front();
        m_ack_r = pop;
        if (push) q.push_back(din);
        m_req_l = push ? 1'b0 : (m_req_l || lvl0 < dp);
        @(posedge clk);
        #1;
        chk("req_l", req_l, m_req_l);
        chk("ack_r", ack_r, m_ack_r);
        chk("dout", dout, m_dout);
        chk("level", level, q.size());
    endtask

    task automatic drain();
        ack_l = 1'b0;
        req_r = '1;
        for (int c = 0; c < 40 && (q.size() > 0 || m_ack_r); c++) cycle();
        chk("drained", level, 0);
        req_r = '0;
    endtask

    initial begin
        int nxt, got_n, v;
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_l", req_l, 0);
        chk("rst_ack_r", ack_r, 0);
        chk("rst_dout", dout, 0);
        chk("rst_level", level, 0);
        rst = 1'b0;
        for (int c = 0; c < 5; c++) cycle();
        chk("idle_req_l", req_l, 1);

        // ordered stream with random producer stalls and stray ack_l while req_l is low
        nxt = 0;
        got_n = 0;
        req_r = '1;
        for (int c = 0; c < 3000 && got_n < 100; c++) begin
            ack_l = $urandom_range(0, 3) != 0;
            din = m_req_l ? nxt : $urandom;
            if (m_req_l && ack_l) nxt++;
            cycle();
            if (m_ack_r) begin
                chk("order", dout, got_n);
                got_n++;
            end
        end
        chk("ordered_count", got_n, 100);
        drain();

        v = 10;
        for (int c = 0; c < 12; c++) begin
            ack_l = v <= 14;
            din = v;
            if (m_req_l && ack_l) v++;
            cycle();
        end
        chk("full_level", level, 4);
        chk("full_req_l", req_l, 0);
        req_r = '1;
        ack_l = 1'b1;
        din = 14;
        cycle();
        chk("first_out", dout, 10);
        req_r = '0;
        for (int c = 0; c < 3; c++) begin
            ack_l = v <= 14;
            din = v;
            if (m_req_l && ack_l) v++;
            cycle();
        end
        chk("refill_level", level, 4);
        drain();

        v = 20;
        for (int c = 0; c < 10 && v < 22; c++) begin
            ack_l = 1'b1;
            din = v;
            if (m_req_l) v++;
            cycle();
        end
        ack_l = 1'b0;
        for (int c = 0; c < 5 && !m_req_l; c++) cycle();
        ack_l = 1'b1;
        din = 22;
        req_r = '1;
        cycle();
        chk("sim_level", level, 2);
        chk("sim_head", dout, 20);
        ack_l = 1'b0;
        req_r = 2'b01;
        for (int c = 0; c < 20; c++) cycle();
        chk("partial_level", level, 2);
        req_r = '1;
        cycle();
        req_r = '0;
        cycle();
        chk("bcast_dout", dout, 21);
        chk("bcast_level", level, 1);

        v = 30;
        for (int c = 0; c < 10 && q.size() < 3; c++) begin
            ack_l = 1'b1;
            din = v;
            if (m_req_l) v++;
            cycle();
        end
        ack_l = 1'b0;
        chk("pre_rst_level", level, 3);
        #2 rst = 1'b1;
        #1;
        chk("async_req_l", req_l, 0);
        chk("async_ack_r", ack_r, 0);
        chk("async_dout", dout, 0);
        chk("async_level", level, 0);
        q.delete();
        m_req_l = 1'b0;
        m_ack_r = 1'b0;
        m_dout = '0;
        #2 rst = 1'b0;
        v = 100;
        seen = 1'b0;
        req_r = '1;
        for (int c = 0; c < 20 && !seen; c++) begin
            ack_l = 1'b1;
            din = v;
            if (m_req_l) v++;
            cycle();
            seen = m_ack_r;
        end
        chk("post_rst_seen", seen, 1);
        chk("post_rst_first", dout, 100);

        for (int c = 0; c < 400; c++) begin
            ack_l = $urandom_range(0, 1);
            din = $urandom;
            req_r = $urandom;
            cycle();
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
